// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types for the hazard controller slice.
//   abi_reg_t    : 5-bit architectural register index
//   ctrl_state_t : hazard FSM state, exported on ctrl_state
package riscvPkg;

  typedef logic [4:0] abi_reg_t;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StSyscall = 2'd2,
    StHalted  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/riscv_load_use_detect.sv
// Load-use hazard comparator (purely combinational).
//   ex_valid, ex_is_load, ex_rd : instruction in EX and its destination
//   id_valid, id_rs1, id_rs2    : instruction in ID and its sources
//   load_use                    : ID reads the register the EX load will write
import riscvPkg::*;

module riscv_load_use_detect (
  input  logic     ex_valid,
  input  logic     ex_is_load,
  input  abi_reg_t ex_rd,
  input  logic     id_valid,
  input  abi_reg_t id_rs1,
  input  abi_reg_t id_rs2,
  output logic     load_use
);

  // x0 is hardwired to zero, so a load into it can never create a dependency.
  assign load_use = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard and syscall/exception control for a 5-stage RISC-V core.
// Inputs : clk, rst (sync, active-high), ID decode info, EX load/redirect info,
//          MEM/WB occupancy, syscall completion handshake.
// Outputs: stall_f, stall_d, bubble_e, flush_d, halted, except_halt, ctrl_state.
import riscvPkg::*;

module riscv_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  abi_reg_t   id_rs1,
  input  abi_reg_t   id_rs2,
  input  logic       id_is_syscall,
  input  logic       id_except_ri,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic       ex_redirect,
  input  abi_reg_t   ex_rd,
  input  logic       mem_valid,
  input  logic       wb_valid,
  input  logic       sys_done,
  input  logic       sys_halt,
  output logic       stall_f,
  output logic       stall_d,
  output logic       bubble_e,
  output logic       flush_d,
  output logic       halted,
  output logic       except_halt,
  output logic [1:0] ctrl_state
);

  ctrl_state_t state_q, state_d;
  logic        drain_ri_q, drain_ri_d;   // DRAIN was entered for a reserved instruction
  logic        except_halt_q, except_halt_d;
  logic        load_use;

  riscv_load_use_detect u_load_use (
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      drain_ri_q    <= 1'b0;
      except_halt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_ri_q    <= drain_ri_d;
      except_halt_q <= except_halt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_ri_d    = drain_ri_q;
    except_halt_d = except_halt_q;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    bubble_e      = 1'b0;
    flush_d       = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          // Taken branch wins: the ID instruction is wrong-path anyway.
          flush_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (id_valid && (id_is_syscall || id_except_ri)) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          bubble_e   = 1'b1;
          drain_ri_d = id_except_ri;
          state_d    = StDrain;
        end else if (load_use) begin
          // One bubble suffices: next cycle EX holds the NOP, not the load.
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end
      end

      StDrain: begin
        if (ex_redirect) begin
          flush_d  = 1'b1;
          bubble_e = 1'b1;
          state_d  = StRun;
        end else if (ex_valid || mem_valid || wb_valid) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (drain_ri_q) begin
          stall_f       = 1'b1;
          stall_d       = 1'b1;
          bubble_e      = 1'b1;
          except_halt_d = 1'b1;
          state_d       = StHalted;
        end else begin
          // Pipe is empty: let the syscall advance out of ID.
          stall_f = 1'b1;
          state_d = StSyscall;
        end
      end

      StSyscall: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (sys_done) begin
          state_d = sys_halt ? StHalted : StRun;
        end
      end

      StHalted: begin
        halted   = 1'b1;
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_e = 1'b1;
      end

      default: state_d = StRun;
    endcase
  end

  assign except_halt = except_halt_q;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
module tb_riscv_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_is_syscall, id_except_ri;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_is_load, ex_redirect, mem_valid, wb_valid;
  logic       sys_done, sys_halt;
  logic       stall_f, stall_d, bubble_e, flush_d, halted, except_halt;
  logic [1:0] ctrl_state;
  logic [4:0] outs;

  int runs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign outs = {stall_f, stall_d, bubble_e, flush_d, halted};

  riscv_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_is_syscall (id_is_syscall),
    .id_except_ri  (id_except_ri),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_redirect   (ex_redirect),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .wb_valid      (wb_valid),
    .sys_done      (sys_done),
    .sys_halt      (sys_halt),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .bubble_e      (bubble_e),
    .flush_d       (flush_d),
    .halted        (halted),
    .except_halt   (except_halt),
    .ctrl_state    (ctrl_state)
  );

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_is_syscall = 1'b0; id_except_ri = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_valid = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
    sys_done = 1'b0; sys_halt = 1'b0;
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (ctrl_state !== 2'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", ctrl_state);
    end
    runs++;
    if (outs !== 5'b00000 || except_halt !== 1'b0) begin
      fails++; $display("FAIL reset_outs: got %b/%b want 00000/0", outs, except_halt);
    end
    runs++;
  endtask

  task automatic test_load_use();
    idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_valid = 1'b1; id_rs1 = 5'd5;
    #1;
    if (outs !== 5'b11100) begin
      fails++; $display("FAIL lu_rs1_stall: got %b want 11100", outs);
    end
    runs++;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;  // EX now holds the injected bubble
    #1;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL lu_one_cycle: got %b want 00000", outs);
    end
    runs++;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd1; id_rs2 = 5'd9;
    #1;
    if (outs !== 5'b11100) begin
      fails++; $display("FAIL lu_rs2_stall: got %b want 11100", outs);
    end
    runs++;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL lu_x0: got %b want 00000", outs);
    end
    runs++;
    ex_rd = 5'd7; id_rs1 = 5'd7; id_valid = 1'b0;
    #1;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL lu_id_invalid: got %b want 00000", outs);
    end
    runs++;
    id_valid = 1'b1; ex_is_load = 1'b0;
    #1;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL lu_not_load: got %b want 00000", outs);
    end
    runs++;
  endtask

  task automatic test_redirect();
    idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_valid = 1'b1; id_rs1 = 5'd5;
    ex_redirect = 1'b1;
    #1;
    if (outs !== 5'b00110) begin
      fails++; $display("FAIL redirect_over_lu: got %b want 00110", outs);
    end
    runs++;
    tick();
    if (ctrl_state !== 2'd0) begin
      fails++; $display("FAIL redirect_state: got %0d want 0", ctrl_state);
    end
    runs++;
  endtask

  task automatic test_syscall(input logic halt_req);
    do_reset();
    id_valid = 1'b1; id_is_syscall = 1'b1;
    ex_valid = 1'b1; mem_valid = 1'b1; wb_valid = 1'b1;
    #1;
    if (outs !== 5'b11100) begin
      fails++; $display("FAIL sc_entry_outs: got %b want 11100", outs);
    end
    runs++;
    // Pipe drains one stage per cycle behind the bubbles.
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_valid = 1'b0; mem_valid = (i == 0); wb_valid = (i < 2);
      #1;
      if (ctrl_state !== 2'd1 || outs !== (i < 2 ? 5'b11100 : 5'b10000)) begin
        fails++;
        $display("FAIL sc_drain_%0d: got state %0d outs %b", i, ctrl_state, outs);
      end
      runs++;
    end
    tick();
    idle();
    ex_redirect = 1'b1;  // ignored in SYSCALL
    #1;
    if (ctrl_state !== 2'd2 || outs !== 5'b10010) begin
      fails++; $display("FAIL sc_wait: got state %0d outs %b want 2/10010", ctrl_state, outs);
    end
    runs++;
    tick();
    ex_redirect = 1'b0;
    if (ctrl_state !== 2'd2) begin
      fails++; $display("FAIL sc_redirect_ignored: got %0d want 2", ctrl_state);
    end
    runs++;
    sys_done = 1'b1; sys_halt = halt_req;
    tick();
    idle();
    #1;
    if (ctrl_state !== (halt_req ? 2'd3 : 2'd0) ||
        outs !== (halt_req ? 5'b11101 : 5'b00000) || except_halt !== 1'b0) begin
      fails++;
      $display("FAIL sc_done_h%0d: got state %0d outs %b eh %b", halt_req, ctrl_state, outs,
               except_halt);
    end
    runs++;
  endtask

  task automatic test_redirect_vs_syscall();
    do_reset();
    id_valid = 1'b1; id_is_syscall = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1;
    #1;
    if (outs !== 5'b00110) begin
      fails++; $display("FAIL sc_redirect_outs: got %b want 00110", outs);
    end
    runs++;
    tick();
    if (ctrl_state !== 2'd0) begin
      fails++; $display("FAIL sc_no_drain: got %0d want 0", ctrl_state);
    end
    runs++;
    ex_redirect = 1'b0;
    tick();
    ex_redirect = 1'b1;
    #1;
    if (ctrl_state !== 2'd1 || outs !== 5'b00110) begin
      fails++; $display("FAIL drain_redirect: got state %0d outs %b", ctrl_state, outs);
    end
    runs++;
    tick();
    idle();
    if (ctrl_state !== 2'd0) begin
      fails++; $display("FAIL drain_redirect_run: got %0d want 0", ctrl_state);
    end
    runs++;
  endtask

  task automatic test_except_ri();
    do_reset();
    id_valid = 1'b1; id_except_ri = 1'b1;
    tick();
    if (ctrl_state !== 2'd1 || outs !== 5'b11100) begin
      fails++; $display("FAIL ri_drain: got state %0d outs %b", ctrl_state, outs);
    end
    runs++;
    tick();
    idle();
    #1;
    if (ctrl_state !== 2'd3 || outs !== 5'b11101 || except_halt !== 1'b1) begin
      fails++;
      $display("FAIL ri_halted: got state %0d outs %b eh %b", ctrl_state, outs, except_halt);
    end
    runs++;
    sys_done = 1'b1; ex_redirect = 1'b1;
    repeat (3) tick();
    if (ctrl_state !== 2'd3 || except_halt !== 1'b1) begin
      fails++; $display("FAIL ri_sticky: got state %0d eh %b", ctrl_state, except_halt);
    end
    runs++;
    do_reset();
    if (ctrl_state !== 2'd0 || outs !== 5'b00000 || except_halt !== 1'b0) begin
      fails++;
      $display("FAIL ri_reset: got state %0d outs %b eh %b", ctrl_state, outs, except_halt);
    end
    runs++;
  endtask

  task automatic test_reset_in_syscall();
    do_reset();
    id_valid = 1'b1; id_is_syscall = 1'b1;
    tick();
    tick();
    idle();
    if (ctrl_state !== 2'd2) begin
      fails++; $display("FAIL rs_reach_syscall: got %0d want 2", ctrl_state);
    end
    runs++;
    rst = 1'b1; sys_done = 1'b1; sys_halt = 1'b1;
    tick();
    idle();
    #1;
    if (ctrl_state !== 2'd0 || outs !== 5'b00000 || except_halt !== 1'b0) begin
      fails++; $display("FAIL rs_syscall: got state %0d outs %b", ctrl_state, outs);
    end
    runs++;
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_syscall(1'b0);
    test_syscall(1'b1);
    // Reset while halted after the syscall.
    rst = 1'b1;
    tick();
    idle();
    #1;
    if (ctrl_state !== 2'd0 || outs !== 5'b00000) begin
      fails++; $display("FAIL rs_halted: got state %0d outs %b", ctrl_state, outs);
    end
    runs++;
    test_redirect_vs_syscall();
    test_except_ri();
    test_reset_in_syscall();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
